// File: rtl/gcd_operand_queue_if.sv
// gcd_operand_queue_if
//   Handshake bundle around the GCD operand-pair queue.
//   Enqueue side : operands_val / operands_rdy / operands_bits_A / operands_bits_B
//   Dequeue side : deq_val / deq_rdy / deq_bits_A / deq_bits_B
//   Status       : count (stored pairs, 0..DEPTH)
//   modport slave  : the queue itself
//   modport master : the surroundings (request source plus GCD unit)
interface gcd_operand_queue_if #(
    parameter int W     = 16,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic         operands_val;
    logic         operands_rdy;
    logic [W-1:0] operands_bits_A;
    logic [W-1:0] operands_bits_B;
    logic         deq_val;
    logic         deq_rdy;
    logic [W-1:0] deq_bits_A;
    logic [W-1:0] deq_bits_B;
    logic [AW:0]  count;

    modport slave (
        input  operands_val, operands_bits_A, operands_bits_B, deq_rdy,
        output operands_rdy, deq_val, deq_bits_A, deq_bits_B, count
    );

    modport master (
        output operands_val, operands_bits_A, operands_bits_B, deq_rdy,
        input  operands_rdy, deq_val, deq_bits_A, deq_bits_B, count
    );
endinterface

// File: rtl/gcd_operand_queue.sv
// gcd_operand_queue
//   Operand-pair FIFO in front of the GCD unit. Buffers up to DEPTH (A, B)
//   pairs so the request source is not stalled while a GCD iterates.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     q        gcd_operand_queue_if.slave (enq handshake, deq handshake, count)
//   Optional build macro GCD_OPQ_BYPASS_EN: when the queue is empty, an
//   incoming pair is presented combinationally on the dequeue side and, if
//   taken that cycle, passes straight through without being stored.
module gcd_operand_queue #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gcd_operand_queue_if.slave    q
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [AW:0]    cnt;
    // Held low through reset and set on the first edge afterwards, so the
    // queue refuses pairs while reset is asserted even though cnt is 0.
    logic           live;

    logic           enq_rdy;
    logic           stored_val;
    logic           pass;
    logic           enq_fire;
    logic           deq_fire;

    assign enq_rdy    = live && (cnt != FULL_CNT);
    assign stored_val = (cnt != '0);

`ifdef GCD_OPQ_BYPASS_EN
    logic bypass;
    // Empty queue: show the incoming pair directly to the GCD unit.
    assign bypass       = live && !stored_val && q.operands_val;
    assign pass         = bypass && q.deq_rdy;
    assign q.deq_val    = stored_val || bypass;
    assign q.deq_bits_A = bypass ? q.operands_bits_A : mem[head][2*W-1:W];
    assign q.deq_bits_B = bypass ? q.operands_bits_B : mem[head][W-1:0];
`else
    assign pass         = 1'b0;
    assign q.deq_val    = stored_val;
    assign q.deq_bits_A = mem[head][2*W-1:W];
    assign q.deq_bits_B = mem[head][W-1:0];
`endif

    assign q.operands_rdy = enq_rdy;
    assign q.count        = cnt;

    // A pair that passes straight through is neither written nor counted.
    assign enq_fire = q.operands_val && enq_rdy && !pass;
    assign deq_fire = stored_val && q.deq_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live <= 1'b0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            live <= 1'b1;
            if (enq_fire) begin
                tail <= tail + AW'(1);
            end
            if (deq_fire) begin
                head <= head + AW'(1);
            end
            if (enq_fire && !deq_fire) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (!enq_fire && deq_fire) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq_fire) begin
            mem[tail] <= {q.operands_bits_A, q.operands_bits_B};
        end
    end

endmodule

// File: tb/tb_gcd_operand_queue.sv
// tb_gcd_operand_queue
//   Directed bench for gcd_operand_queue (W=16, DEPTH=4): reset behaviour,
//   fill/drain, full-boundary and mid-range simultaneous traffic, pointer
//   wrap, first-pair latency (or bypass when GCD_OPQ_BYPASS_EN is defined)
//   and reset in the middle of traffic.
module tb_gcd_operand_queue;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic reset_n;

    int vectors;
    int miscompares;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];

    gcd_operand_queue_if #(.W(W), .DEPTH(DEPTH)) q_if ();

    gcd_operand_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic val, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rdy);
        q_if.operands_val    = val;
        q_if.operands_bits_A = a;
        q_if.operands_bits_B = b;
        q_if.deq_rdy         = rdy;
        #1;
    endtask

    initial begin
        logic [W-1:0] fa [4];
        logic [W-1:0] fb [4];
        vectors     = 0;
        miscompares = 0;
        fa[0] = 27;  fb[0] = 15;
        fa[1] = 49;  fb[1] = 28;
        fa[2] = 8;   fb[2] = 12;
        fa[3] = 100; fb[3] = 75;

        // Reset held with a valid pair on the input.
        reset_n = 1'b0;
        drive(1'b1, 16'd5, 16'd7, 1'b0);
        step();
        step();
        check_val("rst_rdy",   q_if.operands_rdy, 0);
        check_val("rst_val",   q_if.deq_val,      0);
        check_val("rst_count", q_if.count,        0);
        check_val("rst_A",     q_if.deq_bits_A,   0);
        check_val("rst_B",     q_if.deq_bits_B,   0);

        // Release between edges: ready comes up only after the next edge.
        drive(1'b0, 16'd0, 16'd0, 1'b0);
        reset_n = 1'b1;
        #1;
        check_val("rel_rdy_pre", q_if.operands_rdy, 0);
        step();
        check_val("rel_rdy_post", q_if.operands_rdy, 1);

        // Fill to DEPTH with the GCD unit stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fa[i], fb[i], 1'b0);
            step();
            check_val($sformatf("fill_count%0d", i), q_if.count, i + 1);
        end
        check_val("full_rdy", q_if.operands_rdy, 0);

        // Fifth pair must be refused.
        drive(1'b1, 16'd1, 16'd2, 1'b0);
        step();
        check_val("fifth_count", q_if.count,      4);
        check_val("fifth_headA", q_if.deq_bits_A, 27);
        check_val("fifth_headB", q_if.deq_bits_B, 15);

        // Full plus both sides active: only the dequeue fires.
        drive(1'b1, 16'd9, 16'd3, 1'b1);
        check_val("sfull_A", q_if.deq_bits_A, 27);
        check_val("sfull_B", q_if.deq_bits_B, 15);
        step();
        check_val("sfull_count", q_if.count,      3);
        check_val("sfull_headA", q_if.deq_bits_A, 49);
        // Next cycle the waiting pair is taken.
        drive(1'b1, 16'd9, 16'd3, 1'b0);
        step();
        check_val("sfull_enq_count", q_if.count, 4);

        // Drain in order.
        fa[0] = 49; fb[0] = 28;
        fa[1] = 8;  fb[1] = 12;
        fa[2] = 100; fb[2] = 75;
        fa[3] = 9;  fb[3] = 3;
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("drain_val%0d", i), q_if.deq_val,    1);
            check_val($sformatf("drain_A%0d", i),   q_if.deq_bits_A, fa[i]);
            check_val($sformatf("drain_B%0d", i),   q_if.deq_bits_B, fb[i]);
            step();
        end
        check_val("drained_count", q_if.count,   0);
        check_val("drained_val",   q_if.deq_val, 0);

        // Mid-range simultaneous enqueue/dequeue at count 2.
        drive(1'b1, 16'd11, 16'd22, 1'b0);
        step();
        drive(1'b1, 16'd33, 16'd44, 1'b0);
        step();
        check_val("mid_count_pre", q_if.count, 2);
        drive(1'b1, 16'd55, 16'd66, 1'b1);
        check_val("mid_A_pre", q_if.deq_bits_A, 11);
        step();
        check_val("mid_count_post", q_if.count,      2);
        check_val("mid_A_post",     q_if.deq_bits_A, 33);
        check_val("mid_B_post",     q_if.deq_bits_B, 44);

        // Ten back-to-back transfers across the pointer wrap.
        exp_a_q.push_back(16'd33); exp_b_q.push_back(16'd44);
        exp_a_q.push_back(16'd55); exp_b_q.push_back(16'd66);
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] na, nb;
            na = W'(100 + i);
            nb = W'(200 + i);
            drive(1'b1, na, nb, 1'b1);
            check_val($sformatf("wrap_A%0d", i), q_if.deq_bits_A, exp_a_q.pop_front());
            check_val($sformatf("wrap_B%0d", i), q_if.deq_bits_B, exp_b_q.pop_front());
            exp_a_q.push_back(na);
            exp_b_q.push_back(nb);
            step();
            check_val($sformatf("wrap_count%0d", i), q_if.count, 2);
        end
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("wrap_tailA%0d", i), q_if.deq_bits_A, exp_a_q.pop_front());
            check_val($sformatf("wrap_tailB%0d", i), q_if.deq_bits_B, exp_b_q.pop_front());
            step();
        end
        check_val("wrap_end_count", q_if.count, 0);

        // First pair into an empty queue.
        drive(1'b1, 16'd21, 16'd6, 1'b1);
`ifdef GCD_OPQ_BYPASS_EN
        check_val("byp_val", q_if.deq_val,    1);
        check_val("byp_A",   q_if.deq_bits_A, 21);
        check_val("byp_B",   q_if.deq_bits_B, 6);
        step();
        check_val("byp_count", q_if.count, 0);
        drive(1'b0, 16'd0, 16'd0, 1'b0);
`else
        check_val("lat_val_same", q_if.deq_val, 0);
        step();
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        check_val("lat_count", q_if.count,      1);
        check_val("lat_val",   q_if.deq_val,    1);
        check_val("lat_A",     q_if.deq_bits_A, 21);
        check_val("lat_B",     q_if.deq_bits_B, 6);
        step();
        check_val("lat_drained", q_if.count, 0);
`endif

        // Reset in the middle of traffic discards everything at once.
        drive(1'b1, 16'd70, 16'd80, 1'b0);
        step();
        drive(1'b1, 16'd90, 16'd91, 1'b0);
        step();
        check_val("mrst_count_pre", q_if.count, 2);
        reset_n = 1'b0;
        #1;
        check_val("mrst_count", q_if.count,      0);
        check_val("mrst_val",   q_if.deq_val,    0);
        check_val("mrst_A",     q_if.deq_bits_A, 0);
        drive(1'b0, 16'd0, 16'd0, 1'b1);
        step();
        reset_n = 1'b1;
        step();
        step();
        check_val("post_rst_count", q_if.count,        0);
        check_val("post_rst_rdy",   q_if.operands_rdy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
